// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU select codes and divider state type
package alu_pkg;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;
  localparam logic [3:0] SEL_ADD = 4'b0000;
  localparam logic [3:0] SEL_SUB = 4'b0001;
  localparam logic [3:0] SEL_MUL = 4'b0010;
  localparam logic [3:0] SEL_DIV = 4'b0011;
  localparam logic [3:0] SEL_MOD = 4'b0100;
endpackage

// File: rtl/alu_seq_divider_div_step.sv
// div_step: one combinational restoring-division iteration
module div_step #(
  parameter int N = 5
) (
  input  logic [N:0]   R,
  input  logic [N-1:0] Q,
  input  logic [N-1:0] B,
  output logic [N:0]   R_next,
  output logic [N-1:0] Q_next
);
  logic [N:0]   w_sh;
  logic [N-1:0] w_q_sh;
  logic         w_ge;
  assign w_sh   = {R[N-1:0], Q[N-1]};
  assign w_q_sh = Q << 1;
  // a set top bit of R means the shifted value already exceeds any N-bit divisor
  assign w_ge   = R[N] || (w_sh >= {1'b0, B});
  assign R_next = w_ge ? w_sh - {1'b0, B} : w_sh;
  assign Q_next = w_ge ? (w_q_sh | {{(N-1){1'b0}}, 1'b1}) : w_q_sh;
endmodule

// File: rtl/alu_seq_divider.sv
// alu_seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock
module alu_seq_divider
  import alu_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N:0]   quo,
  output logic [N:0]   rem,
  output logic         div_zero
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  div_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [N:0]    r_r, r_quo, r_rem;
  logic [N-1:0]  r_q, r_b;
  logic          r_dz;
  logic [N:0]    w_r_next;
  logic [N-1:0]  w_q_next;
  logic          w_accept;
  assign w_accept = start && (r_state != DIV_RUN);
  div_step #(.N(N)) u_step (
    .R      (r_r),
    .Q      (r_q),
    .B      (r_b),
    .R_next (w_r_next),
    .Q_next (w_q_next)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dz    <= 1'b0;
    end else if (w_accept) begin
      r_b   <= B;
      r_q   <= A;
      r_r   <= '0;
      r_cnt <= CW'(N - 1);
      if (B == '0) begin
        r_state <= DIV_DONE;
        r_quo   <= {1'b0, {N{1'b1}}};
        r_rem   <= {1'b0, A};
        r_dz    <= 1'b1;
      end else begin
        r_state <= DIV_RUN;
      end
    end else if (r_state == DIV_RUN) begin
      r_r   <= w_r_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        r_state <= DIV_DONE;
        r_quo   <= {1'b0, w_q_next};
        r_rem   <= w_r_next;
        r_dz    <= 1'b0;
      end
    end else if (r_state == DIV_DONE) begin
      r_state <= DIV_IDLE;
    end
  end
  assign busy     = (r_state == DIV_RUN);
  assign done     = (r_state == DIV_DONE);
  assign quo      = r_quo;
  assign rem      = r_rem;
  assign div_zero = r_dz;
endmodule
